motor_ctrl_ramp: RTL and testbench

Parametrised successor to the fixed full-on motor direction decoder. It drives the two H-bridge channels with real PWM duty and ramps speed up and down. On any direction reversal it inserts a ramp-down and then a dead-time, so neither bridge is ever switched hard. It sits between the IR command receiver and the motor driver pins, and keeps the same one-hot command codes and driver-side signal names.

---
 rtl/motor_ctrl_ramp.sv | 250 +++++++++++++++++++++++++
 tb/tb_motor_ctrl_ramp.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/motor_ctrl_ramp.sv
// Two-channel H-bridge controller: one-hot command decode, PWM duty ramping, and a
// ramp-down plus dead-time on every direction reversal. Optional watchdog: MOTOR_WATCHDOG_EN.
module motor_ctrl_ramp #(
  parameter int PWM_WIDTH   = 8,
  parameter int RAMP_DIV    = 4,
  parameter int RAMP_STEP   = 16,
  parameter int DEAD_CYCLES = 8,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           IR_input,
  input  logic                 cmd_valid,
  input  logic [PWM_WIDTH-1:0] speed_max,
  output logic                 pwm1,
  output logic                 pwm2,
  output logic                 enable1,
  output logic                 enable2,
  output logic                 ina1,
  output logic                 inb1,
  output logic                 ina2,
  output logic                 inb2,
  output logic                 busy
);

  localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [TW-1:0]        TICK_LAST = TW'(RAMP_DIV - 1);
  localparam logic [DW-1:0]        DEAD_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [PWM_WIDTH:0]   STEP_X    = (PWM_WIDTH+1)'(RAMP_STEP);
  localparam logic [PWM_WIDTH-1:0] DUTY_ZERO = {PWM_WIDTH{1'b0}};
  localparam logic [PWM_WIDTH-1:0] CNT_LAST  = {PWM_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_STOP      = 3'd0,
    ST_BRAKE     = 3'd1,
    ST_BRAKE_HI  = 3'd2,
    ST_RAMP_UP   = 3'd3,
    ST_RUN       = 3'd4,
    ST_RAMP_DOWN = 3'd5,
    ST_DEAD      = 3'd6
  } state_t;

  // Direction word is {ina1, inb1, ina2, inb2}; 4'b0000 means no direction.
  function automatic logic [3:0] decode_dir(input logic [7:0] code);
    case (code)
      8'h02:   return 4'b0101;
      8'h08:   return 4'b0110;
      8'h20:   return 4'b1001;
      8'h80:   return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  // One ramp step toward the goal, clamped at the goal; widened by one bit so it never wraps.
  function automatic logic [PWM_WIDTH-1:0] step_toward(input logic [PWM_WIDTH-1:0] cur,
                                                       input logic [PWM_WIDTH-1:0] goal);
    logic [PWM_WIDTH:0] cur_x, goal_x, res_x;
    cur_x  = {1'b0, cur};
    goal_x = {1'b0, goal};
    if (cur_x < goal_x) begin
      if (cur_x + STEP_X >= goal_x) res_x = goal_x;
      else                          res_x = cur_x + STEP_X;
    end else begin
      if (cur_x >= goal_x + STEP_X) res_x = cur_x - STEP_X;
      else                          res_x = goal_x;
    end
    return res_x[PWM_WIDTH-1:0];
  endfunction

  state_t               state_r, state_nxt_s;
  logic [3:0]           dir_r, dir_nxt_s, pend_r, pend_nxt_s, new_pend_s, cmd_dir_s;
  logic [PWM_WIDTH-1:0] goal_r, goal_nxt_s, duty_next_r, duty_nxt_s, duty_active_r, cnt_r;
  logic                 rev_r, rev_nxt_s, busy_r, busy_nxt_s, enable_r, pwm_r;
  logic [TW-1:0]        tick_r, tick_nxt_s;
  logic [DW-1:0]        dead_r, dead_nxt_s;
  logic                 tick_s, is_motion_s, is_brake_s, is_invalid_s, wdog_fire_s;

`ifdef MOTOR_WATCHDOG_EN
  localparam logic [31:0] WDOG_LIMIT = 32'(WDOG_CYCLES);
  logic [31:0] wdog_r;

  // Idle-time counter, saturating at the limit until the next command arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wdog_r <= 32'd0;
    else if (cmd_valid)            wdog_r <= 32'd0;
    else if (wdog_r != WDOG_LIMIT) wdog_r <= wdog_r + 32'd1;
    else                           wdog_r <= wdog_r;
  end

  assign wdog_fire_s = !cmd_valid && (wdog_r == WDOG_LIMIT);
`else
  // Without the watchdog the last command is held forever.
  assign wdog_fire_s = 1'b0 & (WDOG_CYCLES < 0);
`endif

  assign cmd_dir_s    = decode_dir(IR_input);
  assign is_brake_s   = (cmd_valid && (IR_input == 8'h10)) || wdog_fire_s;
  assign is_motion_s  = cmd_valid && (cmd_dir_s != 4'b0000);
  assign is_invalid_s = cmd_valid && !is_brake_s && !is_motion_s;
  assign new_pend_s   = is_motion_s ? cmd_dir_s : pend_r;
  assign tick_s       = (tick_r == TICK_LAST);

  // Control state, direction, ramp and timing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_STOP;
      dir_r       <= 4'b0000;
      pend_r      <= 4'b0000;
      goal_r      <= DUTY_ZERO;
      rev_r       <= 1'b0;
      duty_next_r <= DUTY_ZERO;
      tick_r      <= {TW{1'b0}};
      dead_r      <= {DW{1'b0}};
      busy_r      <= 1'b0;
      enable_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      dir_r       <= dir_nxt_s;
      pend_r      <= pend_nxt_s;
      goal_r      <= goal_nxt_s;
      rev_r       <= rev_nxt_s;
      duty_next_r <= duty_nxt_s;
      tick_r      <= tick_nxt_s;
      dead_r      <= dead_nxt_s;
      busy_r      <= busy_nxt_s;
      enable_r    <= 1'b1;
    end
  end

  // Next-state, direction and ramp computation.
  always_comb begin
    state_nxt_s = state_r;
    dir_nxt_s   = dir_r;
    goal_nxt_s  = goal_r;
    rev_nxt_s   = rev_r;
    duty_nxt_s  = duty_next_r;
    pend_nxt_s  = new_pend_s;
    if (is_brake_s) begin
      state_nxt_s = ST_BRAKE;
      dir_nxt_s   = 4'b0000;
      duty_nxt_s  = DUTY_ZERO;
    end else if (is_invalid_s) begin
      state_nxt_s = ST_BRAKE_HI;
      dir_nxt_s   = 4'b1111;
      duty_nxt_s  = DUTY_ZERO;
    end else begin
      case (state_r)
        ST_STOP, ST_BRAKE, ST_BRAKE_HI: begin
          if (is_motion_s) begin
            dir_nxt_s   = cmd_dir_s;
            state_nxt_s = ST_RAMP_UP;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_RAMP_UP: begin
          if (new_pend_s != dir_r) begin
            state_nxt_s = ST_RAMP_DOWN;
            goal_nxt_s  = DUTY_ZERO;
            rev_nxt_s   = 1'b1;
          end else if (duty_next_r == speed_max) begin
            state_nxt_s = ST_RUN;
          end else if (tick_s) begin
            duty_nxt_s = step_toward(duty_next_r, speed_max);
          end else begin
            duty_nxt_s = duty_next_r;
          end
        end
        ST_RUN: begin
          if (new_pend_s != dir_r) begin
            state_nxt_s = ST_RAMP_DOWN;
            goal_nxt_s  = DUTY_ZERO;
            rev_nxt_s   = 1'b1;
          end else if (is_motion_s && (speed_max > duty_next_r)) begin
            state_nxt_s = ST_RAMP_UP;
          end else if (is_motion_s && (speed_max < duty_next_r)) begin
            state_nxt_s = ST_RAMP_DOWN;
            goal_nxt_s  = speed_max;
            rev_nxt_s   = 1'b0;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_RAMP_DOWN: begin
          if (duty_next_r == goal_r) begin
            if (rev_r) begin
              state_nxt_s = ST_DEAD;
              dir_nxt_s   = 4'b0000;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else if (tick_s) begin
            duty_nxt_s = step_toward(duty_next_r, goal_r);
          end else begin
            duty_nxt_s = duty_next_r;
          end
        end
        ST_DEAD: begin
          if (dead_r == DEAD_LAST) begin
            dir_nxt_s   = new_pend_s;
            rev_nxt_s   = 1'b0;
            state_nxt_s = ST_RAMP_UP;
          end else begin
            state_nxt_s = ST_DEAD;
          end
        end
        default: begin
          state_nxt_s = ST_STOP;
          dir_nxt_s   = 4'b0000;
          duty_nxt_s  = DUTY_ZERO;
        end
      endcase
    end

    if ((state_nxt_s != state_r) || tick_s) tick_nxt_s = {TW{1'b0}};
    else                                    tick_nxt_s = tick_r + 1'b1;

    if ((state_nxt_s == ST_DEAD) && (state_r == ST_DEAD)) dead_nxt_s = dead_r + 1'b1;
    else                                                 dead_nxt_s = {DW{1'b0}};

    busy_nxt_s = (state_nxt_s == ST_RAMP_UP) || (state_nxt_s == ST_RAMP_DOWN) ||
                 (state_nxt_s == ST_DEAD);
  end

  // Free-running PWM; duty only changes at the period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= DUTY_ZERO;
      duty_active_r <= DUTY_ZERO;
      pwm_r         <= 1'b0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
      if (cnt_r == CNT_LAST) duty_active_r <= duty_next_r;
      else                   duty_active_r <= duty_active_r;
      pwm_r <= (cnt_r < duty_active_r);
    end
  end

  assign pwm1    = pwm_r;
  assign pwm2    = pwm_r;
  assign enable1 = enable_r;
  assign enable2 = enable_r;
  assign ina1    = dir_r[3];
  assign inb1    = dir_r[2];
  assign ina2    = dir_r[1];
  assign inb2    = dir_r[0];
  assign busy    = busy_r;

endmodule

// File: tb/tb_motor_ctrl_ramp.sv
// Directed bench for motor_ctrl_ramp (default parameters, watchdog disabled).
module tb_motor_ctrl_ramp;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ir_input = 8'h00;
  logic       cmd_valid = 1'b0;
  logic [7:0] speed_max = 8'h00;
  logic       pwm1, pwm2, enable1, enable2, ina1, inb1, ina2, inb2, busy;
  logic [3:0] dir;
  int         n_tests = 0;
  int         n_fail = 0;
  int         n, h1, h2;

  assign dir = {ina1, inb1, ina2, inb2};

  motor_ctrl_ramp dut (
    .clk(clk), .rst_n(rst_n), .IR_input(ir_input), .cmd_valid(cmd_valid),
    .speed_max(speed_max), .pwm1(pwm1), .pwm2(pwm2), .enable1(enable1),
    .enable2(enable2), .ina1(ina1), .inb1(inb1), .ina2(ina2), .inb2(inb2), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command for exactly one rising edge; returns on the following falling edge.
  task automatic send(input logic [7:0] code);
    ir_input  = code;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    ir_input  = 8'h00;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic wait_dir_leave(input logic [3:0] from, output int cnt);
    cnt = 0;
    while (dir == from && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic count_pwm(output int c1, output int c2);
    c1 = 0;
    c2 = 0;
    repeat (300) @(negedge clk);
    repeat (256) begin
      @(negedge clk);
      c1 += int'(pwm1);
      c2 += int'(pwm2);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {pwm1, pwm2, enable1, enable2, dir, busy}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("enable_after_reset", {enable1, enable2}, 32'h3);

    // forward at 0x80: 8 ticks of 4 cycles, RUN one cycle later
    speed_max = 8'h80;
    send(8'h02);
    check_eq("fwd_dir", dir, 32'h5);
    check_eq("fwd_busy", busy, 32'h1);
    count_busy(n);
    check_eq("fwd_ramp_cycles", n, 32'd33);
    count_pwm(h1, h2);
    check_eq("fwd_pwm1_high", h1, 32'd128);
    check_eq("fwd_pwm2_high", h2, 32'd128);

    // reversal: ramp down 33, dead 8 with 0000, then 1010 and ramp up 33
    send(8'h80);
    check_eq("rev_dir_held", dir, 32'h5);
    wait_dir_leave(4'b0101, n);
    check_eq("rev_down_cycles", n, 32'd33);
    check_eq("rev_dead_dir", dir, 32'h0);
    wait_dir_leave(4'b0000, n);
    check_eq("rev_dead_cycles", n, 32'd8);
    check_eq("rev_new_dir", dir, 32'hA);
    count_busy(n);
    check_eq("rev_up_cycles", n, 32'd33);
    count_pwm(h1, h2);
    check_eq("rev_pwm_high", h1, 32'd128);

    // retarget down to 0x50 (3 ticks), then up to 0x58 (one saturating tick)
    speed_max = 8'h50;
    send(8'h80);
    count_busy(n);
    check_eq("retgt_down_cycles", n, 32'd13);
    check_eq("retgt_down_dir", dir, 32'hA);
    count_pwm(h1, h2);
    check_eq("retgt_down_pwm", h1, 32'd80);
    speed_max = 8'h58;
    send(8'h80);
    count_busy(n);
    check_eq("retgt_up_sat_cycles", n, 32'd5);
    count_pwm(h1, h2);
    check_eq("retgt_up_pwm", h1, 32'd88);

    // invalid multi-hot code, then left
    send(8'h03);
    check_eq("inval_dir", dir, 32'hF);
    check_eq("inval_busy", busy, 32'h0);
    count_pwm(h1, h2);
    check_eq("inval_pwm", h1 + h2, 32'd0);
    speed_max = 8'h40;
    send(8'h08);
    check_eq("left_dir", dir, 32'h6);
    count_busy(n);
    check_eq("left_ramp_cycles", n, 32'd17);
    count_pwm(h1, h2);
    check_eq("left_pwm", h1, 32'd64);

    // emergency brake at duty 0x30 during ramp-up
    send(8'h10);
    speed_max = 8'h80;
    send(8'h02);
    repeat (12) @(negedge clk);
    check_eq("brk_ramping", busy, 32'h1);
    send(8'h10);
    check_eq("brk_dir", dir, 32'h0);
    check_eq("brk_busy", busy, 32'h0);
    count_pwm(h1, h2);
    check_eq("brk_pwm", h1 + h2, 32'd0);

    // speed_max 0: RAMP_UP completes immediately
    speed_max = 8'h00;
    send(8'h02);
    count_busy(n);
    check_eq("zero_speed_cycles", n, 32'd1);
    check_eq("zero_speed_dir", dir, 32'h5);

    // reversal with two commands during dead time: latest wins
    speed_max = 8'h80;
    send(8'h80);
    send(8'h08);
    send(8'h20);
    check_eq("pend_dead_dir", dir, 32'h0);
    wait_dir_leave(4'b0000, n);
    check_eq("pend_dead_rest", n, 32'd7);
    check_eq("pend_latest_dir", dir, 32'h9);
    check_eq("pend_busy", busy, 32'h1);

    // reset mid-ramp aborts everything
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midramp_reset", {pwm1, pwm2, enable1, enable2, dir, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h00);
    check_eq("zero_code_dir", dir, 32'hF);
    check_eq("zero_code_busy", busy, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
